// File: rtl/tetris_pkg.sv
// Shared types for the Tetris sequencing controller: datapath command codes,
// player move codes, controller state encoding and board geometry defaults.
package tetris_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 4;

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_INIT  = 3'd1,
    CMD_SPAWN = 3'd2,
    CMD_MOVE  = 3'd3,
    CMD_DROP  = 3'd4,
    CMD_LOCK  = 3'd5,
    CMD_CLEAR = 3'd6
  } dp_cmd_e;

  typedef enum logic [1:0] {
    MV_NONE  = 2'b00,
    MV_LEFT  = 2'b01,
    MV_RIGHT = 2'b10,
    MV_ROT   = 2'b11
  } move_e;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_SPAWN     = 4'd2,
    S_SPAWN_CHK = 4'd3,
    S_WAIT      = 4'd4,
    S_MOVE      = 4'd5,
    S_DROP      = 4'd6,
    S_DROP_CHK  = 4'd7,
    S_LOCK      = 4'd8,
    S_CLEAR     = 4'd9,
    S_OVER      = 4'd10
  } state_e;

  // CLEAR only commands the datapath when there is actually a full row.
  function automatic dp_cmd_e state_cmd(input state_e s, input logic any_full);
    case (s)
      S_INIT:  return CMD_INIT;
      S_SPAWN: return CMD_SPAWN;
      S_MOVE:  return CMD_MOVE;
      S_DROP:  return CMD_DROP;
      S_LOCK:  return CMD_LOCK;
      S_CLEAR: return any_full ? CMD_CLEAR : CMD_HOLD;
      default: return CMD_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/tetris_ctrl_if.sv
// Controller <-> datapath/player bundle. master = controller side,
// slave = datapath plus player side.
interface tetris_ctrl_if;
  import tetris_pkg::*;

  logic        move_valid;
  logic [1:0]  move_req;
  logic        touched;
  logic        error;
  logic [31:0] board_in;
  dp_cmd_e     dp_state;
  move_e       dp_move;
  logic        move_ack;

  modport master (
    input  move_valid, move_req, touched, error, board_in,
    output dp_state, dp_move, move_ack
  );

  modport slave (
    output move_valid, move_req, touched, error, board_in,
    input  dp_state, dp_move, move_ack
  );
endinterface

// File: rtl/tetris_ctrl_row_full.sv
// Combinational full-row detector over the locked board; also intended for
// reuse by scoring logic.
module row_full_detect #(
  parameter int ROWS = 8,
  parameter int COLS = 4
) (
  input  logic [31:0] board_in,
  output logic        any_full
);

  always_comb begin
    any_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (&board_in[COLS*r +: COLS]) any_full = 1'b1;
    end
  end

endmodule

// File: rtl/tetris_ctrl.sv
// Sequencing controller for the Tetris datapath: spawn, gravity, move, lock
// and line-clear loop, a one-deep move buffer and a saturating line count.
//
// state     | meaning
// IDLE      | no game, waiting for start
// INIT      | datapath clears the board
// SPAWN     | datapath places a new piece
// SPAWN_CHK | spawn collision -> game over
// WAIT      | gravity countdown, accepts buffered move
// MOVE      | issue buffered move
// DROP      | gravity step
// DROP_CHK  | piece resting -> lock
// LOCK      | datapath merges piece into board
// CLEAR     | remove full rows, bounded by ROWS cycles
// OVER      | game over, waiting for start
module tetris_ctrl
  import tetris_pkg::*;
#(
  parameter int TICK_DIV = 8,
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF
) (
  input  logic          clka,
  input  logic          restart_n,
  input  logic          start,
  tetris_ctrl_if.master bus,
  output logic [7:0]    lines,
  output logic          game_over,
  output logic          busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CLR_LAST    = CW'(ROWS - 1);

  state_e        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [CW-1:0] clr_cnt, clr_nx;
  logic [7:0]    lines_nx;
  logic          buf_valid, buf_valid_nx;
  logic [1:0]    buf_code, buf_code_nx;
  logic          any_full;
  logic          load;
  logic          pending;
  logic [1:0]    pend_code;

  row_full_detect #(.ROWS(ROWS), .COLS(COLS)) u_row_full (
    .board_in (bus.board_in),
    .any_full (any_full)
  );

  // A request arriving in WAIT is issued next cycle without first parking.
  assign load = bus.move_valid && (bus.move_req != MV_NONE) && !buf_valid
                && (state != S_IDLE) && (state != S_OVER);
  assign pending   = buf_valid || load;
  assign pend_code = buf_valid ? buf_code : bus.move_req;

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    clr_nx   = clr_cnt;
    lines_nx = lines;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nx = S_INIT;
          lines_nx = '0;
        end
      end
      S_INIT:  state_nx = S_SPAWN;
      S_SPAWN: state_nx = S_SPAWN_CHK;
      S_SPAWN_CHK: begin
        if (bus.error) begin
          state_nx = S_OVER;
        end else begin
          state_nx = S_WAIT;
          tick_nx  = TICK_RELOAD;
        end
      end
      S_WAIT: begin
        if (pending)         state_nx = S_MOVE;
        else if (tick == '0) state_nx = S_DROP;
        else                 tick_nx  = tick - 1'b1;
      end
      S_MOVE:  state_nx = S_WAIT;
      S_DROP:  state_nx = S_DROP_CHK;
      S_DROP_CHK: begin
        if (bus.touched) begin
          state_nx = S_LOCK;
        end else begin
          state_nx = S_WAIT;
          tick_nx  = TICK_RELOAD;
        end
      end
      S_LOCK: begin
        state_nx = S_CLEAR;
        clr_nx   = '0;
      end
      S_CLEAR: begin
        if (any_full) begin
          if (lines != 8'hFF) lines_nx = lines + 8'd1;
          if (clr_cnt == CLR_LAST) state_nx = S_SPAWN;
          else                     clr_nx   = clr_cnt + 1'b1;
        end else begin
          state_nx = S_SPAWN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Issue wins over load; leaving play discards anything held.
  always_comb begin
    buf_valid_nx = buf_valid;
    buf_code_nx  = buf_code;
    if (state == S_MOVE || state_nx == S_OVER || state_nx == S_IDLE) begin
      buf_valid_nx = 1'b0;
    end else if (load) begin
      buf_valid_nx = 1'b1;
      buf_code_nx  = bus.move_req;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state        <= S_IDLE;
      tick         <= TICK_RELOAD;
      clr_cnt      <= '0;
      buf_valid    <= 1'b0;
      buf_code     <= '0;
      lines        <= '0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
      bus.dp_state <= CMD_HOLD;
      bus.dp_move  <= MV_NONE;
      bus.move_ack <= 1'b0;
    end else begin
      state        <= state_nx;
      tick         <= tick_nx;
      clr_cnt      <= clr_nx;
      buf_valid    <= buf_valid_nx;
      buf_code     <= buf_code_nx;
      lines        <= lines_nx;
      game_over    <= (state_nx == S_OVER);
      busy         <= (state_nx != S_IDLE) && (state_nx != S_OVER);
      bus.dp_state <= state_cmd(state_nx, any_full);
      bus.dp_move  <= (state_nx == S_MOVE) ? move_e'(pend_code) : MV_NONE;
      bus.move_ack <= (state_nx == S_MOVE);
    end
  end

endmodule

// File: tb/tb_tetris_ctrl.sv
// Directed bench for tetris_ctrl with TICK_DIV=4: start-up sequence, gravity
// period, move buffering, tick/move priority, line clears, guard, game over.
module tb_tetris_ctrl;

  logic       clka = 1'b0;
  logic       restart_n;
  logic       start;
  logic [7:0] lines;
  logic       game_over;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;
  int         n;
  int         acks;

  tetris_ctrl_if bus ();

  tetris_ctrl #(.TICK_DIV(4), .ROWS(8), .COLS(4)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .start     (start),
    .bus       (bus),
    .lines     (lines),
    .game_over (game_over),
    .busy      (busy)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc = 1);
    repeat (cyc) begin
      @(posedge clka);
      #1;
    end
  endtask

  initial begin
    restart_n        = 1'b0;
    start            = 1'b0;
    bus.move_valid   = 1'b0;
    bus.move_req     = 2'b00;
    bus.touched      = 1'b0;
    bus.error        = 1'b0;
    bus.board_in     = 32'h0;
    #2;
    chk("rst_dp_state", bus.dp_state, 0);
    chk("rst_dp_move", bus.dp_move, 0);
    chk("rst_move_ack", bus.move_ack, 0);
    chk("rst_lines", lines, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_busy", busy, 0);

    @(negedge clka);
    restart_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);
    start = 1'b1;
    step();                                   // INIT
    start = 1'b0;
    chk("init_cmd", bus.dp_state, 1);
    chk("init_busy", busy, 1);
    chk("init_lines", lines, 0);
    step();
    chk("spawn_cmd", bus.dp_state, 2);
    step();                                   // SPAWN_CHK
    chk("spawn_chk_cmd", bus.dp_state, 0);

    // gravity: 4 WAIT cycles, DROP, DROP_CHK
    step(4);
    chk("wait_hold", bus.dp_state, 0);
    step();
    chk("first_drop", bus.dp_state, 4);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.dp_state !== 3'd4 && n < 20);
    chk("drop_period", n, 6);

    // move request in WAIT, second request while the buffer is full
    step(2);                                  // WAIT, tick=3
    bus.move_valid = 1'b1;
    bus.move_req   = 2'b01;
    step();                                   // MOVE
    chk("move_cmd", bus.dp_state, 3);
    chk("move_code", bus.dp_move, 1);
    chk("move_ack", bus.move_ack, 1);
    bus.move_req = 2'b10;
    step();                                   // WAIT
    bus.move_valid = 1'b0;
    bus.move_req   = 2'b00;
    chk("ack_one_shot", bus.move_ack, 0);
    chk("move_code_idle", bus.dp_move, 0);
    acks = 0;
    repeat (4) begin
      step();
      acks += int'(bus.move_ack);
    end
    chk("no_second_ack", acks, 0);
    chk("drop_after_move", bus.dp_state, 4);

    // move pending with tick already at 0
    step(5);                                  // WAIT, tick=0
    bus.move_valid = 1'b1;
    bus.move_req   = 2'b11;
    step();                                   // MOVE
    bus.move_valid = 1'b0;
    bus.move_req   = 2'b00;
    chk("tick0_move_cmd", bus.dp_state, 3);
    chk("tick0_move_code", bus.dp_move, 3);
    step();
    chk("tick0_wait", bus.dp_state, 0);
    step();
    chk("tick0_drop", bus.dp_state, 4);

    // lock with two full rows showing for two CLEAR evaluations
    bus.touched  = 1'b1;
    bus.board_in = 32'h0000_00FF;
    step();                                   // DROP_CHK
    step();                                   // LOCK
    bus.touched = 1'b0;
    chk("lock_cmd", bus.dp_state, 5);
    step();                                   // CLEAR 1
    chk("clear1_cmd", bus.dp_state, 6);
    chk("clear1_lines", lines, 0);
    step();                                   // CLEAR 2
    chk("clear2_lines", lines, 1);
    step();                                   // CLEAR 3, board now empty
    chk("clear3_lines", lines, 2);
    bus.board_in = 32'h0;
    step();
    chk("respawn_cmd", bus.dp_state, 2);
    chk("lines_held", lines, 2);

    // spawn collision -> OVER, then restart with a stray move request
    step();                                   // SPAWN_CHK
    bus.error = 1'b1;
    step();                                   // OVER
    chk("over_flag", game_over, 1);
    chk("over_cmd", bus.dp_state, 0);
    chk("over_busy", busy, 0);
    bus.error      = 1'b0;
    start          = 1'b1;
    bus.move_valid = 1'b1;
    bus.move_req   = 2'b01;
    step();                                   // INIT
    start          = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_req   = 2'b00;
    chk("restart_cmd", bus.dp_state, 1);
    chk("restart_lines", lines, 0);
    chk("restart_over", game_over, 0);
    step(2);                                  // SPAWN_CHK
    acks = 0;
    repeat (5) begin
      step();
      acks += int'(bus.move_ack);
    end
    chk("over_req_discarded", acks, 0);
    chk("drop_new_game", bus.dp_state, 4);

    // board stuck full: guard ends CLEAR after 8 cycles
    bus.touched  = 1'b1;
    bus.board_in = 32'h0000_00FF;
    step(2);                                  // LOCK
    bus.touched = 1'b0;
    chk("guard_lock_cmd", bus.dp_state, 5);
    n = 0;
    step();
    while (bus.dp_state === 3'd6 && n < 20) begin
      n++;
      step();
    end
    chk("guard_clear_cycles", n, 8);
    chk("guard_spawn", bus.dp_state, 2);
    chk("guard_lines", lines, 8);

    // reset mid-game with a move held in the buffer
    bus.board_in   = 32'h0;
    bus.move_valid = 1'b1;
    bus.move_req   = 2'b01;
    step();                                   // SPAWN_CHK, buffer loaded
    bus.move_valid = 1'b0;
    bus.move_req   = 2'b00;
    #2 restart_n = 1'b0;
    #1;
    chk("midrst_cmd", bus.dp_state, 0);
    chk("midrst_lines", lines, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clka);
    restart_n = 1'b1;
    step();
    start = 1'b1;
    step();                                   // INIT
    start = 1'b0;
    step(3);                                  // SPAWN, SPAWN_CHK, WAIT
    step();
    chk("midrst_buf_flushed", bus.dp_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
